// File: rtl/data_mem_interface.sv
// Multi-cycle bridge from the core data-memory port to a word-wide ready-handshake bus.
// Aligns stores onto byte lanes, extends loads, stalls the core and flags misalignment/faults.
module data_mem_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_read_enable,
  input  logic        core_write_enable,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [2:0]  core_width,
  output logic [31:0] core_read_data,
  output logic        core_stall,
  output logic        core_misaligned,
  output logic        core_fault,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data,
  input  logic        bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Counter value seen in the last permitted WAIT cycle without ready.
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [29:0]              addr_q, addr_d;
  logic [3:0]               be_q, be_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     write_q, write_d;
  logic [2:0]               width_q, width_d;
  logic [1:0]               lane_q, lane_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     fault_q, fault_d;

  logic       access, aligned, timeout_hit;
  logic [3:0] be_st;
  logic [31:0] wd_st;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    access = core_read_enable | core_write_enable;
    case (core_width)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~core_address[0];
      3'b010:         aligned = (core_address[1:0] == 2'b00);
      default:        aligned = 1'b0;
    endcase
    case (core_width[1:0])
      2'b00: begin
        be_st = 4'b0001 << core_address[1:0];
        wd_st = {4{core_write_data[7:0]}};
      end
      2'b01: begin
        be_st = 4'b0011 << {core_address[1], 1'b0};
        wd_st = {2{core_write_data[15:0]}};
      end
      default: begin
        be_st = 4'b1111;
        wd_st = core_write_data;
      end
    endcase
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    write_d = write_q;
    width_d = width_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && aligned) begin
          // Write wins when both enables are high.
          write_d = core_write_enable;
          addr_d  = core_address[31:2];
          be_d    = core_write_enable ? be_st : 4'b1111;
          wdata_d = core_write_enable ? wd_st : '0;
          width_d = core_width;
          lane_d  = core_address[1:0];
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (access) begin
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        if (bus_ready) begin
          fault_d = bus_error;
          rdata_d = (bus_error || write_q) ? '0 : load_extend(bus_read_data, width_q, lane_q);
          state_d = S_DONE;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      width_q <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      width_q <= width_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign core_read_data  = rdata_q;
  assign core_fault      = fault_q;
  assign core_misaligned = (state_q == S_IDLE) && access && !aligned;
  assign core_stall      = reset && (((state_q == S_IDLE) && access && aligned) || (state_q == S_WAIT));
  assign bus_request     = (state_q == S_WAIT);
  assign bus_write       = write_q;
  assign bus_address     = {addr_q, 2'b00};
  assign bus_byte_enable = be_q;
  assign bus_write_data  = wdata_q;

endmodule
